// File: rtl/bus_arbiter.sv
// Two-master (m0 = CPU, m1 = DMA) arbiter onto one shared memory bus, one pending slot per master.
// Optional macro ARB_FIXED_PRIO_EN: m0 always wins ties; default build is round-robin.
module bus_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_rbusy,
  output logic        m0_wbusy,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_rbusy,
  output logic        m1_wbusy,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_rstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_rbusy,
  input  logic        s_wbusy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } slot_t;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic        req_rstrb [2];

  state_t      state_q, state_d;
  slot_t       slot_q [2];
  slot_t       slot_d [2];
  logic        grant_q, grant_d;
  logic        cur_write_q, cur_write_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q [2];
  logic [31:0] rdata_d [2];
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [3:0]  s_wmask_q, s_wmask_d;
  logic        s_rstrb_q, s_rstrb_d;
  logic        pick;
  logic        done;
  logic        rbusy [2];
  logic        wbusy [2];
`ifndef ARB_FIXED_PRIO_EN
  logic        last_q, last_d;
`endif

  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;
  assign req_wmask[0] = m0_wmask;
  assign req_wmask[1] = m1_wmask;
  assign req_rstrb[0] = m0_rstrb;
  assign req_rstrb[1] = m1_rstrb;

  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    pick = ~slot_q[0].valid;
`else
    // On a tie the master that did not win last time goes next.
    if (slot_q[0].valid && slot_q[1].valid) pick = ~last_q;
    else                                    pick = ~slot_q[0].valid;
`endif
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    slot_d      = slot_q;
    grant_d     = grant_q;
    cur_write_d = cur_write_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_wmask_d   = 4'h0;
    s_rstrb_d   = 1'b0;
    done        = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (slot_q[0].valid || slot_q[1].valid) begin
          grant_d     = pick;
          cur_write_d = slot_q[pick].is_write;
          s_addr_d    = slot_q[pick].addr;
          s_wdata_d   = slot_q[pick].wdata;
          s_wmask_d   = slot_q[pick].is_write ? slot_q[pick].wmask : 4'h0;
          s_rstrb_d   = ~slot_q[pick].is_write;
          state_d     = ST_ISSUE;
`ifndef ARB_FIXED_PRIO_EN
          last_d      = pick;
`endif
        end
      end
      ST_ISSUE: begin
        slot_d[grant_q].valid = 1'b0;
        cnt_d                 = LAT_LOAD;
        state_d               = ST_WAIT;
      end
      ST_WAIT: begin
        if (cur_write_q) begin
          done = ~s_wbusy;
        end else if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else if (!s_rbusy) begin
          done             = 1'b1;
          rdata_d[grant_q] = s_rdata;
        end
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A master's slot frees on the completion edge, so a request on that edge is kept.
    for (int i = 0; i < 2; i++) begin
      if (!(slot_q[i].valid ||
            ((state_q != ST_IDLE) && (grant_q == 1'(i)) && !done)) &&
          (req_rstrb[i] || (req_wmask[i] != 4'h0))) begin
        slot_d[i].valid    = 1'b1;
        slot_d[i].is_write = (req_wmask[i] != 4'h0);
        slot_d[i].addr     = req_addr[i];
        slot_d[i].wdata    = req_wdata[i];
        slot_d[i].wmask    = req_wmask[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rbusy[i] = (slot_q[i].valid && !slot_q[i].is_write) ||
                 ((state_q != ST_IDLE) && (grant_q == 1'(i)) && !cur_write_q);
      wbusy[i] = (slot_q[i].valid && slot_q[i].is_write) ||
                 ((state_q != ST_IDLE) && (grant_q == 1'(i)) && cur_write_q);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      cur_write_q <= 1'b0;
      cnt_q       <= 2'd0;
      s_addr_q    <= 32'h0;
      s_wdata_q   <= 32'h0;
      s_wmask_q   <= 4'h0;
      s_rstrb_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
      // NOTE: the slot and read-data arrays are plain flops, so they are reset like any register.
      for (int i = 0; i < 2; i++) begin
        slot_q[i]  <= '0;
        rdata_q[i] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cur_write_q <= cur_write_d;
      cnt_q       <= cnt_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wmask_q   <= s_wmask_d;
      s_rstrb_q   <= s_rstrb_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
      for (int i = 0; i < 2; i++) begin
        slot_q[i]  <= slot_d[i];
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
  assign m0_rbusy = rbusy[0];
  assign m1_rbusy = rbusy[1];
  assign m0_wbusy = wbusy[0];
  assign m1_wbusy = wbusy[1];
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wmask  = s_wmask_q;
  assign s_rstrb  = s_rstrb_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model and a small slave memory.
module tb_bus_arbiter;

  localparam int RD_LATENCY = 1;

  typedef struct {
    logic        rd;
    logic [3:0]  wm;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_rstrb, m0_rbusy, m0_wbusy, m1_rstrb, m1_rbusy, m1_wbusy;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb, s_rbusy, s_wbusy;

  always #5 clk = ~clk;

  bus_arbiter #(.RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: pending request per master plus the one transaction on the bus.
  req_t        rq [2];
  logic        in_rb, in_wb, in_rst;
  logic        pv [2];
  logic        pw [2];
  logic [31:0] pa [2];
  logic [31:0] pd [2];
  logic [3:0]  pm [2];
  int          cur, ph, last;
  logic        cur_w;
  int          caps [2];
  logic [31:0] e_rdata [2];
  logic        e_rbusy [2];
  logic        e_wbusy [2];
  logic        e_rstrb;
  logic [3:0]  e_wmask;
  logic [31:0] e_saddr, e_swdata;

  // Slave side: small word memory, read data held from strobe until the next one.
  logic [31:0] mem [16];
  logic [31:0] rd_hold = 32'h0;
  int          rstrb_count = 0;
  int          wmask_count = 0;
  int          grant_log [$];

  function automatic req_t nop();
    req_t r;
    r.rd = 1'b0; r.wm = 4'h0; r.addr = 32'h0; r.wdata = 32'h0;
    return r;
  endfunction

  function automatic req_t rd(input logic [31:0] a);
    req_t r;
    r = nop(); r.rd = 1'b1; r.addr = a;
    return r;
  endfunction

  function automatic req_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    req_t r;
    r = nop(); r.wm = m; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   k;
    r = nop();
    k = $urandom_range(0, 5);
    r.addr  = 32'($urandom_range(0, 15)) << 2;
    r.wdata = $urandom;
    if (k == 0 || k == 2) r.rd = 1'b1;
    if (k == 1 || k == 2) r.wm = 4'($urandom_range(1, 15));
    return r;
  endfunction

  function automatic void model_reset();
    cur = -1; ph = 0; last = 1; cur_w = 1'b0;
    e_rstrb = 1'b0; e_wmask = 4'h0; e_saddr = 32'h0; e_swdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pw[i] = 1'b0; pa[i] = 32'h0; pd[i] = 32'h0; pm[i] = 4'h0;
      caps[i] = 0; e_rdata[i] = 32'h0; e_rbusy[i] = 1'b0; e_wbusy[i] = 1'b0;
    end
  endfunction

  // What the arbiter should show after one rising edge, given the inputs of the closing cycle.
  function automatic void model_edge();
    logic done;
    logic blk [2];
    int   sel;
    if (in_rst) begin
      model_reset();
      return;
    end
    done = (cur >= 0) && (ph >= 2) &&
           (cur_w ? !in_wb : (((ph - 1) >= RD_LATENCY) && !in_rb));
    for (int i = 0; i < 2; i++) blk[i] = pv[i] || ((cur == i) && !done);
    e_rstrb = 1'b0;
    e_wmask = 4'h0;
    if (cur < 0) begin
      if (pv[0] || pv[1]) begin
`ifdef ARB_FIXED_PRIO_EN
        sel = pv[0] ? 0 : 1;
`else
        sel = (pv[0] && pv[1]) ? (1 - last) : (pv[0] ? 0 : 1);
        last = sel;
`endif
        cur = sel; cur_w = pw[sel]; ph = 1;
        e_saddr = pa[sel]; e_swdata = pd[sel];
        if (pw[sel]) e_wmask = pm[sel];
        else         e_rstrb = 1'b1;
      end
    end else if (ph == 1) begin
      pv[cur] = 1'b0;
      ph = 2;
    end else if (done) begin
      if (!cur_w) e_rdata[cur] = s_rdata;
      cur = -1;
    end else begin
      ph++;
    end
    for (int i = 0; i < 2; i++) begin
      if (!blk[i] && (rq[i].rd || rq[i].wm != 4'h0)) begin
        pv[i] = 1'b1; pw[i] = (rq[i].wm != 4'h0);
        pa[i] = rq[i].addr; pd[i] = rq[i].wdata; pm[i] = rq[i].wm;
        caps[i]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      e_rbusy[i] = (pv[i] && !pw[i]) || ((cur == i) && !cur_w);
      e_wbusy[i] = (pv[i] && pw[i])  || ((cur == i) && cur_w);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("m0_rbusy", 32'(m0_rbusy), 32'(e_rbusy[0]));
    chk("m0_wbusy", 32'(m0_wbusy), 32'(e_wbusy[0]));
    chk("m1_rbusy", 32'(m1_rbusy), 32'(e_rbusy[1]));
    chk("m1_wbusy", 32'(m1_wbusy), 32'(e_wbusy[1]));
    chk("m0_rdata", m0_rdata, e_rdata[0]);
    chk("m1_rdata", m1_rdata, e_rdata[1]);
    chk("s_rstrb",  32'(s_rstrb), 32'(e_rstrb));
    chk("s_wmask",  32'(s_wmask), 32'(e_wmask));
    chk("s_addr",   s_addr, e_saddr);
    chk("s_wdata",  s_wdata, e_swdata);
  endtask

  task automatic slave_react();
    if (s_rstrb === 1'b1) begin
      rstrb_count++;
      rd_hold = mem[s_addr[5:2]];
      grant_log.push_back(int'(s_addr[11]));
    end
    if (s_wmask !== 4'h0) begin
      wmask_count++;
      for (int b = 0; b < 4; b++)
        if (s_wmask[b]) mem[s_addr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
      grant_log.push_back(int'(s_addr[11]));
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, then compare on the falling edge.
  task automatic tick(input req_t a, input req_t b, input logic rb, input logic wb, input logic rst);
    rq[0] = a; rq[1] = b; in_rb = rb; in_wb = wb; in_rst = rst;
    m0_addr = a.addr; m0_wdata = a.wdata; m0_wmask = a.wm; m0_rstrb = a.rd;
    m1_addr = b.addr; m1_wdata = b.wdata; m1_wmask = b.wm; m1_rstrb = b.rd;
    s_rbusy = rb; s_wbusy = wb; reset_n = ~rst;
    s_rdata = rb ? $urandom : rd_hold;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_all();
    slave_react();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(nop(), nop(), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(nop(), nop(), 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0;
    int          exp_order [6];
    logic [31:0] exp_val;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0101_0101 * 32'(i);
    mem[0] = 32'hDEAD_BEEF;
    model_reset();

    // Reset state.
    do_reset();
    do_reset();
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);

    // m0 read, minimum latency.
    n0 = rstrb_count;
    tick(rd(32'h100), nop(), 1'b0, 1'b0, 1'b0);
    chk("rd_T1_rbusy", 32'(m0_rbusy), 32'd1);
    idle(1);
    chk("rd_T2_rstrb", 32'(s_rstrb), 32'd1);
    chk("rd_T2_addr", s_addr, 32'h100);
    idle(1);
    chk("rd_T3_rbusy", 32'(m0_rbusy), 32'd1);
    idle(1);
    chk("rd_T4_rbusy", 32'(m0_rbusy), 32'd0);
    chk("rd_T4_rdata", m0_rdata, 32'hDEAD_BEEF);
    idle(3);
    chk("rd_one_strobe", 32'(rstrb_count - n0), 32'd1);

    // Simultaneous writes after reset: m0 first, then m1.
    do_reset();
    tick(wr(32'h10, 32'h1111_1111, 4'hF), wr(32'h20, 32'h2222_2222, 4'hF), 1'b0, 1'b0, 1'b0);
    chk("wr_T1_m1_wbusy", 32'(m1_wbusy), 32'd1);
    idle(1);
    chk("wr_T2_addr", s_addr, 32'h10);
    chk("wr_T2_wdata", s_wdata, 32'h1111_1111);
    idle(2);
    chk("wr_T4_m0_wbusy", 32'(m0_wbusy), 32'd0);
    chk("wr_T4_m1_wbusy", 32'(m1_wbusy), 32'd1);
    idle(1);
    chk("wr_T5_addr", s_addr, 32'h20);
    chk("wr_T5_wmask", 32'(s_wmask), 32'hF);
    idle(2);
    chk("wr_T7_m1_wbusy", 32'(m1_wbusy), 32'd0);
    chk("wr_mem_m0", mem[4], 32'h1111_1111);
    chk("wr_mem_m1", mem[8], 32'h2222_2222);

    // Three back-to-back simultaneous reads from each master.
    do_reset();
    grant_log.delete();
    for (int n = 0; n < 200; n++) begin
      if (caps[0] == 3 && caps[1] == 3 && cur < 0 && !pv[0] && !pv[1]) break;
      tick((caps[0] < 3) ? rd(32'(caps[0] * 4)) : nop(),
           (caps[1] < 3) ? rd(32'h800 + 32'(caps[1] * 4)) : nop(),
           1'b0, 1'b0, 1'b0);
    end
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 1, 1, 1};
`else
    exp_order = '{0, 1, 0, 1, 0, 1};
`endif
    chk("rr_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_grant%0d", i),
          (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));

    // Slave read stall of three extra cycles.
    do_reset();
    exp_val = mem[1];
    n0 = rstrb_count;
    tick(rd(32'h104), nop(), 1'b0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) tick(nop(), nop(), 1'b1, 1'b0, 1'b0);
    chk("stall_T6_rbusy", 32'(m0_rbusy), 32'd1);
    idle(1);
    chk("stall_T7_rbusy", 32'(m0_rbusy), 32'd0);
    chk("stall_rdata", m0_rdata, exp_val);
    chk("stall_one_strobe", 32'(rstrb_count - n0), 32'd1);

    // Reset while an m1 write is stalled on the slave.
    do_reset();
    tick(nop(), wr(32'h30, 32'hCAFE_F00D, 4'b0011), 1'b0, 1'b1, 1'b0);
    tick(nop(), nop(), 1'b0, 1'b1, 1'b0);
    tick(nop(), nop(), 1'b0, 1'b1, 1'b0);
    tick(nop(), nop(), 1'b0, 1'b1, 1'b0);
    n0 = wmask_count;
    tick(nop(), nop(), 1'b0, 1'b1, 1'b1);
    chk("abort_m1_wbusy", 32'(m1_wbusy), 32'd0);
    chk("abort_wmask", 32'(s_wmask), 32'h0);
    idle(3);
    chk("abort_no_wmask", 32'(wmask_count - n0), 32'd0);
    tick(nop(), rd(32'h104), 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("abort_m1_rdata", m1_rdata, exp_val);
    chk("abort_m1_rbusy", 32'(m1_rbusy), 32'd0);

    // Random traffic with random slave stalls and occasional resets.
    do_reset();
    for (int n = 0; n < 600; n++)
      tick(rand_req(), rand_req(), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 199) == 0));
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: RD_LATENCY, default 1, cycles from s_rstrb to valid s_rdata (range 1..4).
REQ-002 clk  input  1  single system clock, all logic on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 m{0,1}_addr  input  32  master byte address (m0 = CPU, m1 = DMA).
REQ-005 m{0,1}_wdata  input  32  master write data.
REQ-006 m{0,1}_wmask  input  4  master byte-write strobe; nonzero for one cycle = write request.
REQ-007 m{0,1}_rstrb  input  1  master one-cycle read request.
REQ-008 m{0,1}_rdata  output  32  registered read data returned to master.
REQ-009 m{0,1}_rbusy  output  1  read-in-progress stall to master.
REQ-010 m{0,1}_wbusy  output  1  write-in-progress stall to master.
REQ-011 s_addr, s_wdata  output  32 each  shared-bus address and write data.
REQ-012 s_wmask  output  4  shared-bus byte-write strobe.
REQ-013 s_rstrb  output  1  shared-bus read strobe.
REQ-014 s_rdata  input  32  shared-bus read data.
REQ-015 s_rbusy, s_wbusy  input  1 each  slave stall inputs.

Function
REQ-016 Per master, one pending slot (valid, addr, wdata, wmask, is_write) SHALL capture a request on the edge where m_rstrb=1 or m_wmask!=0; both set -> treated as write.
REQ-017 A new request from a master whose slot is valid or in flight SHALL be ignored.
REQ-018 m_rbusy SHALL be 1 while that master's read slot is pending or in flight; m_wbusy likewise for writes; both 0 otherwise.
REQ-019 FSM states: IDLE, ISSUE, WAIT.
REQ-020 IDLE: if any slot valid, select one (REQ-026), go ISSUE next cycle; else stay.
REQ-021 ISSUE: drive s_addr/s_wdata from selected slot for exactly one cycle with s_rstrb=1 (read) or s_wmask=slot wmask (write); clear slot valid; go WAIT.
REQ-022 WAIT read: count RD_LATENCY cycles after ISSUE, then wait for s_rbusy=0; on that edge latch s_rdata into m_rdata, drop m_rbusy next cycle, go IDLE.
REQ-023 WAIT write: on first cycle with s_wbusy=0, drop m_wbusy next cycle, go IDLE.
REQ-024 Outside ISSUE, s_rstrb=0 and s_wmask=0; s_addr/s_wdata hold last issued values.
REQ-025 Minimum latency, RD_LATENCY=1, uncontended: request cycle T, ISSUE T+2, m_rdata valid with m_rbusy=0 at T+4.
REQ-026 Round-robin: with both slots valid, grant the master not granted last; single valid slot granted directly.
REQ-027 m_rdata SHALL hold its value until the next completed read for that master; writes do not alter it.
REQ-028 Request captured in same cycle as arbiter completion for same master: honored (slot free at that edge).

Reset
REQ-029 reset_n=0 at a rising edge SHALL clear all slots, counter and in-flight state, FSM -> IDLE, last-grant -> m1 (so m0 wins first tie).
REQ-030 During/after reset: all busy outputs 0, s_rstrb=0, s_wmask=0, s_addr=0, s_wdata=0, m_rdata=0.
REQ-031 Reset mid-transaction SHALL abort it with no further slave strobe.

Configuration
REQ-032 Macro ARB_FIXED_PRIO_EN defined: m0 always wins ties, last-grant state unused; undefined: round-robin per REQ-026.

Verification
REQ-033 m0 read 0x100, slave returns 0xDEADBEEF, RD_LATENCY=1 -> one s_rstrb, m0_rdata=0xDEADBEEF at T+4, m0_rbusy high T+1..T+3.
REQ-034 m0 and m1 write same cycle (0x10/0x11111111, 0x20/0x22222222) after reset -> m0 issued first, m1 on next ISSUE; m1_wbusy held until its completion.
REQ-035 Back-to-back simultaneous reads x3 -> grants m0,m1,m0,m1,m0,m1 (round-robin); with ARB_FIXED_PRIO_EN, each m0 request issued before any waiting m1.
REQ-036 s_rbusy held 3 extra cycles -> m_rbusy extends 3 cycles, s_rstrb not re-pulsed, data latched on release.
REQ-037 reset_n=0 during WAIT of m1 write -> all busy 0 next cycle, no s_wmask, FSM IDLE; fresh m1 read then completes normally.
